fbuf_writer: RTL and testbench



---
 rtl/fbuf_writer.sv | 130 +++++++++++++
 tb/tb_fbuf_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fbuf_writer.sv
// rtl/fbuf_writer.sv - double-buffered frame buffer writer with tear-free swap on display eof
module fbuf_writer #(
  parameter int FRAME_WIDTH     = 4,
  parameter int FRAME_HEIGHT    = 4,
  parameter int FBUF_ADDR_WIDTH = 8,
  parameter int PIXEL_WIDTH     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIXEL_WIDTH-1:0]   s_pixel_data,
  input  logic                     s_pixel_sof,
  input  logic                     s_pixel_valid,
  output logic                     s_pixel_ready,
  input  logic                     eof,
  output logic                     wr_en,
  output logic [FBUF_ADDR_WIDTH:0] wr_addr,
  output logic [PIXEL_WIDTH-1:0]   wr_data,
  output logic                     disp_buf_sel,
  output logic                     frame_done,
  output logic                     sync_error
);

  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_IDX = FBUF_ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] IDX_ONE  = FBUF_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic [FBUF_ADDR_WIDTH-1:0] idx, idx_next;
  logic [FBUF_ADDR_WIDTH-1:0] wr_idx;
  logic                       sel_next;
  logic                       accept;
  logic                       beat_write;
  logic                       last_beat;
  logic                       restart;

  assign accept = s_pixel_valid && s_pixel_ready;

  // State, pixel index and displayed-half register; reset aborts any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      disp_buf_sel <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      disp_buf_sel <= sel_next;
    end
  end

  // Next state: decide whether this beat is written, where, and whether the frame completes
  always_comb begin
    state_next = state;
    idx_next   = idx;
    sel_next   = disp_buf_sel;
    wr_idx     = '0;
    beat_write = 1'b0;
    restart    = 1'b0;
    last_beat  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Beats without sof are dropped so we lock onto the next frame start
        if (accept && s_pixel_sof) begin
          beat_write = 1'b1;
          wr_idx     = '0;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          beat_write = 1'b1;
          restart    = s_pixel_sof;
          wr_idx     = s_pixel_sof ? '0 : idx;
        end
      end
      ST_DONE: begin
        // Swap only once a full frame sits in the back half; the reader moves to it
        if (eof) begin
          sel_next   = ~disp_buf_sel;
          state_next = ST_IDLE;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
    if (beat_write) begin
      last_beat = (wr_idx == LAST_IDX);
      if (last_beat) begin
        state_next = ST_DONE;
        idx_next   = '0;
      end else begin
        state_next = ST_WRITE;
        idx_next   = wr_idx + IDX_ONE;
      end
    end
  end

  // Outputs: ready depends on state alone so the producer sees no valid-to-ready path
  always_comb begin
    s_pixel_ready = (state != ST_DONE);
  end

  // Registered RAM write port and status pulses, one cycle behind the accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      wr_en      <= beat_write;
      frame_done <= beat_write && last_beat;
      sync_error <= restart;
      if (beat_write) begin
        wr_addr <= {~disp_buf_sel, wr_idx};
        wr_data <= s_pixel_data;
      end
    end
  end

endmodule

// File: tb/tb_fbuf_writer.sv
// tb/tb_fbuf_writer.sv - vector table plus write scoreboard for fbuf_writer
module tb_fbuf_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_pixel_data = '0;
  logic        s_pixel_sof = 1'b0;
  logic        s_pixel_valid = 1'b0;
  logic        s_pixel_ready;
  logic        eof = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [23:0] wr_data;
  logic        disp_buf_sel;
  logic        frame_done;
  logic        sync_error;

  int checks = 0;
  int errors = 0;

  fbuf_writer #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(4), .FBUF_ADDR_WIDTH(8), .PIXEL_WIDTH(24)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_pixel_data(s_pixel_data), .s_pixel_sof(s_pixel_sof),
    .s_pixel_valid(s_pixel_valid), .s_pixel_ready(s_pixel_ready),
    .eof(eof), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_buf_sel(disp_buf_sel), .frame_done(frame_done), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        sof;
    logic        eof;
    logic [23:0] data;
    logic        exp_ready;
    logic        exp_sel;
    logic        exp_wr;
    logic [8:0]  exp_addr;
    logic        exp_fd;
    logic        exp_se;
  } vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic [23:0] data;
    logic        fd;
    logic        se;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic s, input logic e, input logic [23:0] d,
                     input logic rdy, input logic sel, input logic wr, input logic [8:0] a,
                     input logic fd, input logic se);
    vec_t x;
    x.valid = v; x.sof = s; x.eof = e; x.data = d;
    x.exp_ready = rdy; x.exp_sel = sel; x.exp_wr = wr;
    x.exp_addr = a; x.exp_fd = fd; x.exp_se = se;
    vecs.push_back(x);
  endtask

  task automatic push_exp(input logic [8:0] a, input logic [23:0] d, input logic fd, input logic se);
    exp_t x;
    x.addr = a; x.data = d; x.fd = fd; x.se = se;
    sb.push_back(x);
  endtask

  // Write monitor: every wr_en must match the oldest outstanding expectation
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("write", {29'd0, wr_addr, wr_data, frame_done, sync_error},
                {29'd0, x.addr, x.data, x.fd, x.se});
        end
      end else begin
        check("idle_pulses", {62'd0, frame_done, sync_error}, 64'd0);
      end
    end
  end

  initial begin
    // Frame 1 into half 1, data 0..15
    for (int i = 0; i < 16; i++)
      add(1, i == 0, 0, 24'(i), 1, 0, 1, 9'(256 + i), i == 15, 0);
    add(1, 0, 0, 24'd99, 0, 0, 0, 9'd0, 0, 0);
    add(0, 0, 0, 24'd0, 0, 0, 0, 9'd0, 0, 0);
    add(0, 0, 1, 24'd0, 0, 0, 0, 9'd0, 0, 0);
    // Frame 2 into half 0 after the swap
    for (int i = 0; i < 16; i++)
      add(1, i == 0, 0, 24'(512 + i), 1, 1, 1, 9'(i), i == 15, 0);
    add(0, 0, 1, 24'd0, 0, 1, 0, 9'd0, 0, 0);
    // Resync: beats without sof are dropped
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 24'(768 + i), 1, 0, 0, 9'd0, 0, 0);
    // Five beats, then a mid-frame sof restarts at index 0; eof rides on the last beat
    for (int i = 0; i < 5; i++)
      add(1, i == 0, 0, 24'(784 + i), 1, 0, 1, 9'(256 + i), 0, 0);
    for (int i = 0; i < 16; i++)
      add(1, i == 0, i == 15, 24'(800 + i), 1, 0, 1, 9'(256 + i), i == 15, i == 0);
    add(0, 0, 0, 24'd0, 0, 0, 0, 9'd0, 0, 0);
    add(0, 0, 1, 24'd0, 0, 0, 0, 9'd0, 0, 0);
    // Frame 4 into half 0, then swap back
    for (int i = 0; i < 16; i++)
      add(1, i == 0, 0, 24'(1024 + i), 1, 1, 1, 9'(i), i == 15, 0);
    add(0, 0, 1, 24'd0, 0, 1, 0, 9'd0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(s_pixel_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_sel", 64'(disp_buf_sel), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_sync_error", 64'(sync_error), 64'd0);

    // Table-driven run
    foreach (vecs[k]) begin
      @(negedge clk);
      s_pixel_valid = vecs[k].valid;
      s_pixel_sof   = vecs[k].sof;
      s_pixel_data  = vecs[k].data;
      eof           = vecs[k].eof;
      #1;
      check($sformatf("ready[%0d]", k), 64'(s_pixel_ready), 64'(vecs[k].exp_ready));
      check($sformatf("sel[%0d]", k), 64'(disp_buf_sel), 64'(vecs[k].exp_sel));
      if (vecs[k].exp_wr)
        push_exp(vecs[k].exp_addr, vecs[k].data, vecs[k].exp_fd, vecs[k].exp_se);
    end
    @(negedge clk);
    s_pixel_valid = 1'b0; s_pixel_sof = 1'b0; eof = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained_table", 64'(sb.size()), 64'd0);

    // Reset at beat 8 aborts the frame without a swap
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_pixel_valid = 1'b1; s_pixel_sof = (i == 0); s_pixel_data = 24'(1280 + i);
      #1;
      push_exp(9'(256 + i), 24'(1280 + i), 1'b0, 1'b0);
    end
    @(negedge clk);
    s_pixel_valid = 1'b0; s_pixel_sof = 1'b0;
    rst_n = 1'b0;
    #1;
    check("sb_drained_reset", 64'(sb.size()), 64'd0);
    check("mid_rst_ready", 64'(s_pixel_ready), 64'd1);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    check("mid_rst_sel", 64'(disp_buf_sel), 64'd0);
    check("mid_rst_pulses", {62'd0, frame_done, sync_error}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // After reset: non-sof beat dropped, sof beat lands at index 0 of half 1
    @(negedge clk);
    s_pixel_valid = 1'b1; s_pixel_sof = 1'b0; s_pixel_data = 24'h0000aa;
    #1;
    check("post_rst_ready", 64'(s_pixel_ready), 64'd1);
    @(negedge clk);
    s_pixel_sof = 1'b1; s_pixel_data = 24'h000600;
    #1;
    push_exp(9'h100, 24'h000600, 1'b0, 1'b0);
    @(negedge clk);
    s_pixel_valid = 1'b0; s_pixel_sof = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained_final", 64'(sb.size()), 64'd0);
    check("final_sel", 64'(disp_buf_sel), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
